lemon_ifu: RTL and testbench
============================

// Module: lemon_ifu
// PURPOSE
//  Multi-cycle instruction fetch unit for LemonPC; sits directly upstream of decode/execute.
//  Owns the architectural PC and issues one 32-bit fetch at a time to instruction memory
//  over a valid/ready request + valid response interface.
//  Presents {pc, inst} to the downstream stage over valid/ready.
//  Accepts redirects (dnpc from branch/jump) and a halt request (ebreak).
// PARAMETERS
//  PC_INIT   64'h8000_0000  PC value after reset
//  INST_LEN  4              byte increment of sequential PC
// PORTS
//  clk              in   1   single clock, rising edge
//  rst_n            in   1   asynchronous, active-low reset
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request this cycle
//  imem_req_addr    out  64  fetch address (= pc)
//  imem_resp_valid  in   1   fetch data valid; exactly one per accepted request
//  imem_resp_data   in   32  fetched instruction
//  out_valid        out  1   {out_pc, out_inst} valid to decode
//  out_ready        in   1   decode consumes this cycle
//  out_pc           out  64  PC of presented instruction
//  out_inst         out  32  presented instruction
//  redirect_valid   in   1   replace PC with redirect_pc
//  redirect_pc      in   64  target; bits[1:0] forced to 0 on capture
//  halt             in   1   stop fetching (level, sampled per rule below)
//  halted           out  1   FSM is in S_HALT
// BEHAVIOUR
//  Reset (async assert, sync release): state=S_IDLE, pc=PC_INIT, out_valid=0,
//   out_pc=PC_INIT, out_inst=0, drop=0; imem_req_valid=0, halted=0.
//  FSM, all outputs from registers or state only (no in->out comb paths except none):
//   S_IDLE: -> S_REQ unconditionally (first request the cycle after reset release).
//   S_REQ : imem_req_valid=1, addr=pc. req_ready=1 -> S_WAIT.
//   S_WAIT: await resp. resp_valid & !drop -> latch out_inst=resp_data, out_pc=pc,
//           out_valid=1, -> S_OUT. resp_valid & drop -> drop=0, -> S_REQ.
//   S_OUT : out_valid=1. out_ready -> out_valid=0, pc=pc+INST_LEN (64-bit wrap),
//           -> S_HALT if halt else S_REQ.
//   S_HALT: no requests, out_valid=0, halted=1; exits only via reset.
//  Single outstanding request; max throughput 1 inst / 3 cycles (REQ,WAIT,OUT) at
//   zero-wait memory. Latency reset-release -> first out_valid = 3 cycles min.
//  Redirect (highest priority, ignored in S_HALT and S_IDLE):
//   S_REQ, req_ready=0: pc=redirect_pc, stay S_REQ (addr changes next cycle).
//   S_REQ, req_ready=1: old request accepted; pc=redirect_pc, drop=1, -> S_WAIT.
//   S_WAIT: pc=redirect_pc; if resp_valid same cycle -> discard, -> S_REQ; else drop=1.
//   S_OUT: out_valid=0 next cycle (even if out_ready=1, handshake still counts as
//           consumed), pc=redirect_pc (no +4), -> S_REQ.
//  Halt sampled only in S_OUT on handshake; halt elsewhere has no effect.
//  imem_req_valid, once high, holds addr stable until accepted unless redirected.
//  Response arriving outside S_WAIT is a protocol error: ignored; sim-only assertion fires.
// STRUCTURE
//  defines.v gains: `IFU_S_IDLE/REQ/WAIT/OUT/HALT (3-bit encodings), `PC_INIT, `inst_len.
//  Single module; no sub-module needed (pc adder is inline, not an alu instance).
// TESTING
//  T1 reset release, req_ready=1, resp 1 cycle later, out_ready=1 -> addrs 0x80000000,
//     0x80000004, 0x80000008 in order; out_valid every 3rd cycle; out_pc matches.
//  T2 out_ready=0 for 5 cycles in S_OUT -> out_valid, out_pc, out_inst held; no new req.
//  T3 redirect_pc=0x80000103 in S_WAIT, resp 2 cycles later -> that resp dropped,
//     next req addr 0x80000100, next out_pc 0x80000100.
//  T4 redirect + resp_valid same cycle -> resp discarded, no out_valid, req at target.
//  T5 halt=1 at handshake of inst at 0x80000010 -> halted=1, no further req_valid ever.
//  T6 rst_n low mid-S_WAIT -> all outputs at reset values immediately; refetch 0x80000000.

Source files
------------

// File: rtl/lemon_ifu_pkg.sv
// lemon_ifu_pkg: shared types and constants for the LemonPC fetch unit.
// FSM state encoding, reset PC / step defaults, PC alignment helper.
package lemon_ifu_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_OUT  = 3'd3,
    S_HALT = 3'd4
  } ifu_state_e;

  localparam logic [63:0] IFU_PC_INIT  = 64'h8000_0000;
  localparam int unsigned IFU_INST_LEN = 4;

  function automatic logic [63:0] align_pc(
    input logic [63:0] a
  );
    return {a[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/lemon_ifu.sv
// lemon_ifu: multi-cycle fetch unit, one outstanding imem request,
// presents {pc, inst} to decode over valid/ready.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req_valid/ready/addr        fetch request (addr = pc)
//   imem_resp_valid/data             fetch response, one per request
//   out_valid/ready, out_pc/inst     instruction to decode
//   redirect_valid/pc                branch/jump target
//   halt / halted                    stop request / in halt state
module lemon_ifu
  import lemon_ifu_pkg::*;
#(
  parameter logic [63:0] PC_INIT  = IFU_PC_INIT,
  parameter int unsigned INST_LEN = IFU_INST_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  ifu_state_e  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        drop_q, drop_d;
  logic [63:0] tgt;

  assign tgt = align_pc(redirect_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_INIT;
      out_pc_q   <= PC_INIT;
      out_inst_q <= 32'd0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      out_pc_q   <= out_pc_d;
      out_inst_q <= out_inst_d;
      drop_q     <= drop_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_pc_d   = out_pc_q;
    out_inst_d = out_inst_q;
    drop_d     = drop_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect_valid) begin
          pc_d = tgt;
          // Old request still goes out; its response is stale.
          if (imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_d = tgt;
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            out_inst_d = imem_resp_data;
            out_pc_d   = pc_q;
            state_d    = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (redirect_valid) begin
          pc_d    = tgt;
          state_d = S_REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 64'(INST_LEN);
          state_d = halt ? S_HALT : S_REQ;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign out_valid      = (state_q == S_OUT);
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign halted         = (state_q == S_HALT);

`ifndef SYNTHESIS
  // A response outside S_WAIT has no matching request.
  a_resp_in_wait: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem_resp_valid |-> (state_q == S_WAIT)
  );
`endif

endmodule

// File: tb/tb_lemon_ifu.sv
// tb_lemon_ifu: directed tests for lemon_ifu.
// Inputs change and outputs are sampled on the falling edge.
module tb_lemon_ifu;

  localparam logic [63:0] PCI = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        halted;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lemon_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .halted          (halted)
  );

  function automatic logic [31:0] mk(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'd0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 64'd0;
    halt = 1'b0;
    repeat (2) tick();
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL rst_req_valid got %b want 0", imem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b0 || halted !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid_halted got %b%b want 00",
               out_valid, halted);
    end
    checks++;
    if (out_pc !== PCI || imem_req_addr !== PCI) begin
      errs++;
      $display("FAIL rst_pc got %h/%h want %h",
               out_pc, imem_req_addr, PCI);
    end
    checks++;
    if (out_inst !== 32'd0) begin
      errs++;
      $display("FAIL rst_inst got %h want 0", out_inst);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_seq();
    logic [63:0] a;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = PCI + 64'(4 * i);
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== a
          || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL seq_req%0d got v=%b a=%h ov=%b want 1 %h 0",
                 i, imem_req_valid, imem_req_addr, out_valid, a);
      end
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
        errs++;
        $display("FAIL seq_wait%0d got rv=%b ov=%b want 0 0",
                 i, imem_req_valid, out_valid);
      end
      imem_resp_valid = 1'b1;
      imem_resp_data = mk(a);
      tick();
      imem_resp_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_pc !== a
          || out_inst !== mk(a)) begin
        errs++;
        $display("FAIL seq_out%0d got v=%b pc=%h i=%h want 1 %h %h",
                 i, out_valid, out_pc, out_inst, a, mk(a));
      end
    end
  endtask

  task automatic test_stall();
    logic [63:0] a;
    a = PCI + 64'h0c;
    tick();
    checks++;
    if (imem_req_addr !== a) begin
      errs++;
      $display("FAIL stall_req got %h want %h", imem_req_addr, a);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = mk(a);
    out_ready = 1'b0;
    tick();
    imem_resp_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== a || out_inst !== mk(a)
          || imem_req_valid !== 1'b0) begin
        errs++;
        $display("FAIL stall_hold%0d got v=%b pc=%h i=%h rv=%b",
                 j, out_valid, out_pc, out_inst, imem_req_valid);
      end
      tick();
    end
    out_ready = 1'b1;
  endtask

  task automatic test_halt();
    logic [63:0] a;
    logic seen;
    a = PCI + 64'h10;
    tick();
    halt = 1'b1;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== a) begin
      errs++;
      $display("FAIL halt_req got %b %h want 1 %h",
               imem_req_valid, imem_req_addr, a);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = mk(a);
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== a || halted !== 1'b0) begin
      errs++;
      $display("FAIL halt_out got v=%b pc=%h h=%b want 1 %h 0",
               out_valid, out_pc, halted, a);
    end
    tick();
    checks++;
    if (halted !== 1'b1 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL halt_state got h=%b ov=%b want 1 0",
               halted, out_valid);
    end
    seen = 1'b0;
    repeat (12) begin
      if (imem_req_valid !== 1'b0 || halted !== 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errs++;
      $display("FAIL halt_stay got req/exit=%b want 0", seen);
    end
  endtask

  task automatic test_reset_mid_wait();
    halt = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = mk(PCI);
    tick();
    imem_resp_valid = 1'b0;
    tick();
    checks++;
    if (imem_req_addr !== PCI + 64'h4) begin
      errs++;
      $display("FAIL rmw_req got %h want %h",
               imem_req_addr, PCI + 64'h4);
    end
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0
        || halted !== 1'b0) begin
      errs++;
      $display("FAIL rmw_flags got rv=%b ov=%b h=%b want 000",
               imem_req_valid, out_valid, halted);
    end
    checks++;
    if (imem_req_addr !== PCI || out_pc !== PCI
        || out_inst !== 32'd0) begin
      errs++;
      $display("FAIL rmw_regs got a=%h pc=%h i=%h want %h %h 0",
               imem_req_addr, out_pc, out_inst, PCI, PCI);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== PCI) begin
      errs++;
      $display("FAIL rmw_refetch got %b %h want 1 %h",
               imem_req_valid, imem_req_addr, PCI);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = mk(PCI);
    tick();
    imem_resp_valid = 1'b0;
  endtask

  task automatic test_redirect_wait();
    logic [63:0] t;
    t = 64'h8000_0100;
    tick();
    checks++;
    if (imem_req_addr !== PCI + 64'h4) begin
      errs++;
      $display("FAIL rdw_req got %h want %h",
               imem_req_addr, PCI + 64'h4);
    end
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0103;
    tick();
    redirect_valid = 1'b0;
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hdead_beef;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1
        || imem_req_addr !== t) begin
      errs++;
      $display("FAIL rdw_drop got ov=%b rv=%b a=%h want 0 1 %h",
               out_valid, imem_req_valid, imem_req_addr, t);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = mk(t);
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== t || out_inst !== mk(t)) begin
      errs++;
      $display("FAIL rdw_out got v=%b pc=%h i=%h want 1 %h %h",
               out_valid, out_pc, out_inst, t, mk(t));
    end
  endtask

  task automatic test_redirect_same();
    logic [63:0] t;
    t = 64'h8000_0200;
    tick();
    checks++;
    if (imem_req_addr !== 64'h8000_0104) begin
      errs++;
      $display("FAIL rds_req got %h want 80000104", imem_req_addr);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hbad0_0bad;
    redirect_valid = 1'b1;
    redirect_pc = t;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1
        || imem_req_addr !== t) begin
      errs++;
      $display("FAIL rds_disc got ov=%b rv=%b a=%h want 0 1 %h",
               out_valid, imem_req_valid, imem_req_addr, t);
    end
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data = mk(t);
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== t) begin
      errs++;
      $display("FAIL rds_out got v=%b pc=%h want 1 %h",
               out_valid, out_pc, t);
    end
  endtask

  task automatic test_redirect_out_req();
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0300;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1
        || imem_req_addr !== 64'h8000_0300) begin
      errs++;
      $display("FAIL rdo_req got ov=%b rv=%b a=%h want 0 1 80000300",
               out_valid, imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0402;
    tick();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0400) begin
      errs++;
      $display("FAIL rdr_stall got rv=%b a=%h want 1 80000400",
               imem_req_valid, imem_req_addr);
    end
    imem_req_ready = 1'b1;
    redirect_pc = 64'h8000_0500;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errs++;
      $display("FAIL rdr_acc got rv=%b want 0", imem_req_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0bad_f00d;
    tick();
    imem_resp_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1
        || imem_req_addr !== 64'h8000_0500) begin
      errs++;
      $display("FAIL rdr_drop got ov=%b rv=%b a=%h want 0 1 80000500",
               out_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_seq();
    test_stall();
    test_halt();
    test_reset_mid_wait();
    test_redirect_wait();
    test_redirect_same();
    test_redirect_out_req();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
